fetch_insn_queue: RTL and testbench

Instruction queue between the fetch stage and the decode stage. Captures each fetched {pc, instruction} pair under a valid/ready handshake and buffers up to DEPTH entries, so a decode stall back-pressures fetch without dropping instructions. A flush, raised on a taken branch, discards all buffered wrong-path instructions. When the queue is empty, decode is presented a canonical NOP.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_iq_storage.sv | 27 ++
 rtl/fetch_insn_queue.sv | 99 +++++++++
 tb/tb_fetch_insn_queue.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-side instruction queue.
// Holds the canonical NOP, the queue entry layout and a pointer-width helper.
package fetch_pkg;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } iq_entry_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fetch_iq_storage.sv
// Entry array for the fetch instruction queue: one write port, one async read.
// No reset; occupancy is tracked by the owner of the pointers.
module fetch_iq_storage
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic            i_clk,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  iq_entry_t       i_wdata,
    input  logic [AW-1:0]   i_raddr,
    output iq_entry_t       o_rdata
);

    iq_entry_t r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_insn_queue.sv
// Fetch-to-decode instruction queue with flush and NOP-when-empty output.
// Define FETCH_IQ_BYPASS_EN for a zero-latency path through an empty queue.
module fetch_insn_queue #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INSN = fetch_pkg::NOP_INSN
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_flush,
    input  logic                       i_valid,
    input  logic [31:0]                i_pc,
    input  logic [31:0]                i_insn,
    output logic                       o_ready,
    output logic                       o_valid,
    output logic [31:0]                o_pc,
    output logic [31:0]                o_insn,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH):0]     o_count
);

    import fetch_pkg::*;

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic      w_empty;
    logic      w_full;
    logic      w_push;
    logic      w_pop;
    logic      w_byp;
    iq_entry_t w_wdata;
    iq_entry_t w_head;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign o_ready = ~w_full;
    assign o_count = r_count;

    assign w_wdata.pc   = i_pc;
    assign w_wdata.insn = i_insn;

`ifdef FETCH_IQ_BYPASS_EN
    assign w_byp = w_empty & i_valid & ~i_flush;
`else
    assign w_byp = 1'b0;
`endif

    // A bypassed instruction taken by decode this cycle is never stored.
    assign w_push = i_valid & o_ready & ~i_flush & ~(w_byp & i_ready);
    assign w_pop  = ~w_empty & i_ready & ~i_flush;

    always_comb begin
        o_valid = 1'b0;
        o_pc    = 32'h0;
        o_insn  = NOP_INSN;
        if (!w_empty) begin
            o_valid = 1'b1;
            o_pc    = w_head.pc;
            o_insn  = w_head.insn;
        end else if (w_byp) begin
            o_valid = 1'b1;
            o_pc    = i_pc;
            o_insn  = i_insn;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    fetch_iq_storage #(
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_storage (
        .i_clk   (i_clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

endmodule

// File: tb/tb_fetch_insn_queue.sv
// Directed self-checking bench for fetch_insn_queue (DEPTH=2).
// Streaming and wrap-around sections target the default non-bypass build.
module tb_fetch_insn_queue;

    logic        i_clk;
    logic        i_rst;
    logic        i_flush;
    logic        i_valid;
    logic [31:0] i_pc;
    logic [31:0] i_insn;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_pc;
    logic [31:0] o_insn;
    logic        i_ready;
    logic [1:0]  o_count;

    int n_checks = 0;
    int n_fails  = 0;

    fetch_insn_queue #(
        .DEPTH    (2),
        .NOP_INSN (32'h0000_0013)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_flush),
        .i_valid (i_valid),
        .i_pc    (i_pc),
        .i_insn  (i_insn),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_pc    (o_pc),
        .o_insn  (o_insn),
        .i_ready (i_ready),
        .o_count (o_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] mk(input logic [31:0] pc);
        return pc ^ 32'h00A0_0093;
    endfunction

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc);
        i_valid = v;
        i_pc    = pc;
        i_insn  = mk(pc);
        #1;
    endtask

    int          q[$];
    int          sent;
    int          got;
    logic [31:0] exp_seq[7];
    logic        w_push;
    logic        w_pop;

    initial begin
        i_rst   = 1'b1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_pc    = 32'h0;
        i_insn  = 32'h0;
        i_ready = 1'b0;
        tick();
        tick();
        i_rst = 1'b0;
        #1;
        check("rst_valid", 64'(o_valid), 64'(0));
        check("rst_insn",  64'(o_insn),  64'h13);
        check("rst_pc",    64'(o_pc),    64'h0);
        check("rst_ready", 64'(o_ready), 64'(1));
        check("rst_count", 64'(o_count), 64'(0));

`ifndef FETCH_IQ_BYPASS_EN
        // Streaming: one cycle latency, occupancy steady at 1.
        i_ready = 1'b1;
        drive(1'b1, 32'h0);
        check("str_pre_valid", 64'(o_valid), 64'(0));
        tick();
        drive(1'b1, 32'h4);
        check("str_pc0",   64'(o_pc),    64'h0);
        check("str_insn0", 64'(o_insn),  64'(mk(32'h0)));
        check("str_cnt0",  64'(o_count), 64'(1));
        tick();
        drive(1'b1, 32'h8);
        check("str_pc1",   64'(o_pc),    64'h4);
        check("str_cnt1",  64'(o_count), 64'(1));
        tick();
        drive(1'b0, 32'h0);
        check("str_pc2",   64'(o_pc),    64'h8);
        check("str_cnt2",  64'(o_count), 64'(1));
        tick();
        check("str_empty", 64'(o_valid), 64'(0));
        check("str_nop",   64'(o_insn),  64'h13);
`endif

        // Back-pressure
        i_ready = 1'b0;
        drive(1'b1, 32'h100);
        tick();
        drive(1'b1, 32'h104);
        tick();
        drive(1'b1, 32'h108);
        check("bp_cnt_full", 64'(o_count), 64'(2));
        check("bp_ready",    64'(o_ready), 64'(0));
        check("bp_head0",    64'(o_pc),    64'h100);
        tick();
        check("bp_hold_cnt", 64'(o_count), 64'(2));
        check("bp_hold_pc",  64'(o_pc),    64'h100);
        i_ready = 1'b1;
        #1;
        tick();
        check("bp_head1", 64'(o_pc),    64'h104);
        check("bp_cnt1",  64'(o_count), 64'(1));
        tick();
        drive(1'b0, 32'h0);
        check("bp_head2", 64'(o_pc),    64'h108);
        check("bp_ins2",  64'(o_insn),  64'(mk(32'h108)));
        tick();
        check("bp_drain", 64'(o_valid), 64'(0));
        check("bp_dcnt",  64'(o_count), 64'(0));

        // Flush while full with a same-cycle push attempt
        i_ready = 1'b0;
        drive(1'b1, 32'h300);
        tick();
        drive(1'b1, 32'h304);
        tick();
        check("fl_cnt_pre", 64'(o_count), 64'(2));
        i_flush = 1'b1;
        drive(1'b1, 32'h200);
        tick();
        i_flush = 1'b0;
        drive(1'b0, 32'h0);
        check("fl_valid", 64'(o_valid), 64'(0));
        check("fl_count", 64'(o_count), 64'(0));
        check("fl_ready", 64'(o_ready), 64'(1));
        tick();
        check("fl_nopush", 64'(o_valid), 64'(0));

        // Flush with one entry, where the push would otherwise fit
        drive(1'b1, 32'h400);
        tick();
        check("fl1_cnt_pre", 64'(o_count), 64'(1));
        i_flush = 1'b1;
        i_ready = 1'b1;
        drive(1'b1, 32'h204);
        tick();
        i_flush = 1'b0;
        drive(1'b0, 32'h0);
        check("fl1_count", 64'(o_count), 64'(0));
        check("fl1_pc",    64'(o_pc),    64'h0);
        tick();
        check("fl1_after", 64'(o_count), 64'(0));

`ifndef FETCH_IQ_BYPASS_EN
        // Wrap-around with mixed stalls against a small queue model
        for (int k = 0; k < 7; k++) exp_seq[k] = 32'h1000 + 32'(4 * k);
        q.delete();
        sent = 0;
        got  = 0;
        for (int c = 0; c < 60 && got < 7; c++) begin
            i_ready = ((c % 3) != 1);
            drive((sent < 7) && ((c % 4) != 2),
                  32'h1000 + 32'(4 * sent));
            check("wr_count", 64'(o_count), 64'(q.size()));
            if (q.size() > 0) begin
                check("wr_pc",   64'(o_pc),   64'(q[0]));
                check("wr_insn", 64'(o_insn), 64'(mk(32'(q[0]))));
            end
            w_push = i_valid && (q.size() < 2);
            w_pop  = (q.size() > 0) && i_ready;
            tick();
            if (w_pop) begin
                check("wr_order", 64'(q[0]), 64'(exp_seq[got]));
                void'(q.pop_front());
                got++;
            end
            if (w_push) begin
                q.push_back(int'(i_pc));
                sent++;
            end
        end
        check("wr_all_out", 64'(got), 64'(7));
        drive(1'b0, 32'h0);
        check("wr_empty", 64'(o_valid), 64'(0));
`else
        // Bypass through an empty queue
        i_ready = 1'b1;
        drive(1'b1, 32'h40);
        check("by_valid", 64'(o_valid), 64'(1));
        check("by_pc",    64'(o_pc),    64'h40);
        check("by_insn",  64'(o_insn),  64'(mk(32'h40)));
        tick();
        drive(1'b0, 32'h0);
        check("by_cnt0", 64'(o_count), 64'(0));
        i_ready = 1'b0;
        drive(1'b1, 32'h44);
        check("by_valid2", 64'(o_valid), 64'(1));
        check("by_pc2",    64'(o_pc),    64'h44);
        tick();
        drive(1'b0, 32'h0);
        check("by_cnt1", 64'(o_count), 64'(1));
        check("by_head", 64'(o_pc),    64'h44);
        i_ready = 1'b1;
        #1;
        tick();
        check("by_drain", 64'(o_count), 64'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
